relu_map_sched: RTL and testbench
=================================

# relu_map_sched

Row-sequenced ReLU/requantization controller for one MAP_SIZE x MAP_SIZE feature map held in the accumulator buffer. On `start`, it reads the map row by row from a synchronous-read buffer. Each row passes through MAP_SIZE parallel ReLU/shift/saturate lanes in a single registered stage, and the 8-bit result is written row by row into the output feature-map buffer. The block sits between the conv accumulator buffer and the next layer's input buffer, and replaces the fully parallel map-wide ReLU array with a MAP_SIZE-lane datapath.

## Interface
- BUF_WIDTH, 26, signed accumulator element width
- OUT_WIDTH, 8, signed output element width
- MAP_SIZE, 16, map height/width; also the lane count
- SHIFT_W, 5, width of the requantization shift field
- AW, $clog2(MAP_SIZE), row address width
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- cfg_shift  in  SHIFT_W  arithmetic right shift; latched on accepted start
- busy  out  1  high from the cycle after an accepted start through the last write
- done  out  1  one-cycle pulse after the last row write
- rd_en  out  1  input-buffer read strobe
- rd_addr  out  AW  input row index
- rd_data  in  MAP_SIZE*BUF_WIDTH  row data, valid one cycle after rd_en; element j at bits [(j+1)*BUF_WIDTH-1 -: BUF_WIDTH]
- wr_en  out  1  output-buffer write strobe
- wr_addr  out  AW  output row index
- wr_data  out  MAP_SIZE*OUT_WIDTH  result row; same element packing as rd_data
- neg_cnt  out  $clog2(MAP_SIZE*MAP_SIZE+1)  number of elements clamped to zero in the last run
- sat_flag  out  1  sticky per run: some element saturated high

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE → RUN on start.
  - Accepting start latches cfg_shift and clears neg_cnt, sat_flag and the row counter.
- RUN: each cycle, rd_en=1 and rd_addr=row, then row increments.
  - On row==MAP_SIZE-1 the FSM goes to DRAIN.
- DRAIN: 2 cycles, letting the read latency and the ReLU register empty. Then → DONE.
- DONE: done=1 for one cycle, then → IDLE.
- start outside IDLE is ignored. There is no queueing.
- Lane arithmetic, per element x (signed BUF_WIDTH):
  - if x<0, the result is 0 and neg_cnt increments;
  - otherwise y = x >>> cfg_shift; if y > 2^(OUT_WIDTH-1)-1, the result is 2^(OUT_WIDTH-1)-1 and sat_flag is set; otherwise the result is y[OUT_WIDTH-1:0].
  - x==0 gives 0 and is not counted as negative.
- neg_cnt accumulates the popcount of negative lanes per row. It cannot overflow: its maximum is MAP_SIZE².
- neg_cnt and sat_flag hold their values after done until the next accepted start.
- wr_addr is a delayed copy of rd_addr (two-stage pipeline), so rows are written in order 0..MAP_SIZE-1.

## Timing
- Cycle numbering: start is sampled high in IDLE at edge 0.
- Read for row k is issued at cycle 1+k; rd_data is valid at cycle 2+k; wr_en/wr_addr=k/wr_data are registered at cycle 3+k.
- Throughput is 1 row per cycle with no bubbles. Latency from start to first write is 3 cycles.
- The last write is at cycle MAP_SIZE+2. done pulses at cycle MAP_SIZE+3, and busy is low in that same cycle.
- busy is high for cycles 1..MAP_SIZE+2.
- start is accepted again in the cycle after done, when the FSM is back in IDLE.
- Reset (asynchronous, any state, including mid-run) forces:
  - IDLE, with busy, done, rd_en and wr_en = 0;
  - rd_addr, wr_addr, wr_data, neg_cnt, sat_flag and the latched shift = 0.
  - A partial map is not completed, and no write occurs after reset asserts.
- cfg_shift ≥ BUF_WIDTH gives y=0 for non-negative inputs.

## Structure
- Shared package holds:
  - the FSM state enum;
  - the element-slice helper (index j → bit range);
  - the saturation constant 2^(OUT_WIDTH-1)-1.
- One sub-module, `relu_lane`, is combinational: x and shift in; y, is_neg and is_sat out.
  - The top instantiates MAP_SIZE lanes and owns the single result register, the popcount, the FSM and the counters.

## Test plan
Bench uses MAP_SIZE=4 and a buffer model with 1-cycle read latency.
- Ramp map: element (r,j) = r*4+j, shift=0 → rows written as 0..15 unchanged; neg_cnt=0; sat_flag=0; done at cycle 7.
- Negatives: every odd element = -5, the rest 3, shift=0 → odd lanes 0, even lanes 3; neg_cnt=8.
- Saturation: one element 1000 with shift=2 gives 250 → 127 and sat_flag=1; another element 400 with shift=2 gives 100 → 100.
- Reset mid-run: assert rst_n=0 at cycle 4 → outputs immediately 0, and no further wr_en. A new start after release gives a full 4-row run with correct data.
- start pulsed during busy and in the done cycle → ignored. start held high → runs back-to-back with a 1-cycle IDLE gap, and cfg_shift is re-latched per run.
- Boundaries: x=0 → 0 and not counted; x=-1 → 0 and counted; shift=31 on max positive → 0.

Source files
------------

// File: rtl/relu_map_sched_pkg.sv
// Shared types and helpers for the row-sequenced ReLU/requantization controller.
package relu_map_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // LSB of element j in a row packed at w bits per element
    function automatic int elem_lsb(input int j, input int w);
        return j * w;
    endfunction

    // Largest positive value of a signed out_w-bit result
    function automatic int sat_max(input int out_w);
        return (1 << (out_w - 1)) - 1;
    endfunction

endpackage

// File: rtl/relu_map_sched_lane.sv
// One ReLU/shift/saturate lane: negative -> 0, else arithmetic shift clamped to max positive.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module relu_lane
    import relu_map_sched_pkg::*;
#(
    parameter int BUF_WIDTH = 26,
    parameter int OUT_WIDTH = 8,
    parameter int SHIFT_W   = 5
) (
    input  logic signed [BUF_WIDTH-1:0] x,
    input  logic        [SHIFT_W-1:0]   shift,
    output logic        [OUT_WIDTH-1:0] y,
    output logic                        is_neg,
    output logic                        is_sat
);

    localparam logic signed [BUF_WIDTH-1:0] SAT = BUF_WIDTH'(sat_max(OUT_WIDTH));

    logic signed [BUF_WIDTH-1:0] shifted;

    // Shifts past the element width sign-fill, so non-negative inputs become 0
    assign shifted = x >>> shift;

    always_comb begin
        is_neg = x[BUF_WIDTH-1];
        is_sat = !is_neg && (shifted > SAT);
        y      = shifted[OUT_WIDTH-1:0];
        if (is_neg) begin
            y = '0;
        end else if (is_sat) begin
            y = SAT[OUT_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/relu_map_sched.sv
// Reads a MAP_SIZE x MAP_SIZE map row by row, applies MAP_SIZE ReLU lanes, writes 8-bit rows.
// Latency: first write 3 cycles after start, one row per cycle, done at MAP_SIZE+3.
// Backpressure: none; buffers must accept a read and a write every cycle, start ignored unless idle.
module relu_map_sched
    import relu_map_sched_pkg::*;
#(
    parameter int BUF_WIDTH = 26,
    parameter int OUT_WIDTH = 8,
    parameter int MAP_SIZE  = 16,
    parameter int SHIFT_W   = 5,
    parameter int AW        = $clog2(MAP_SIZE),
    parameter int NEG_W     = $clog2(MAP_SIZE * MAP_SIZE + 1)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic [SHIFT_W-1:0]              cfg_shift,
    output logic                            busy,
    output logic                            done,
    output logic                            rd_en,
    output logic [AW-1:0]                   rd_addr,
    input  logic [MAP_SIZE*BUF_WIDTH-1:0]   rd_data,
    output logic                            wr_en,
    output logic [AW-1:0]                   wr_addr,
    output logic [MAP_SIZE*OUT_WIDTH-1:0]   wr_data,
    output logic [NEG_W-1:0]                neg_cnt,
    output logic                            sat_flag
);

    state_t                       state, state_nxt;
    logic [AW-1:0]                row;
    logic                         drain_cnt;
    logic [SHIFT_W-1:0]           shift_q;
    logic                         start_acc;
    logic                         rd_vld_q;
    logic [AW-1:0]                rd_addr_q;
    logic [MAP_SIZE-1:0]          lane_neg;
    logic [MAP_SIZE-1:0]          lane_sat;
    logic [MAP_SIZE*OUT_WIDTH-1:0] lane_y;
    logic [NEG_W-1:0]             row_neg;

    always_comb begin
        state_nxt = state;
        start_acc = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                    start_acc = 1'b1;
                end
            end
            RUN:   if (row == AW'(MAP_SIZE - 1)) state_nxt = DRAIN;
            DRAIN: if (drain_cnt) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        rd_en = (state == RUN);
        busy  = (state == RUN) || (state == DRAIN);
        done  = (state == DONE);
    end

    assign rd_addr = row;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            row       <= '0;
            drain_cnt <= 1'b0;
            shift_q   <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
            if (start_acc) begin
                row     <= '0;
                shift_q <= cfg_shift;
            end else if (state == RUN) begin
                row <= row + 1'b1;
            end
        end
    end

    for (genvar j = 0; j < MAP_SIZE; j++) begin : g_lane
        relu_lane #(
            .BUF_WIDTH (BUF_WIDTH),
            .OUT_WIDTH (OUT_WIDTH),
            .SHIFT_W   (SHIFT_W)
        ) u_lane (
            .x      (rd_data[elem_lsb(j, BUF_WIDTH) +: BUF_WIDTH]),
            .shift  (shift_q),
            .y      (lane_y[elem_lsb(j, OUT_WIDTH) +: OUT_WIDTH]),
            .is_neg (lane_neg[j]),
            .is_sat (lane_sat[j])
        );
    end

    always_comb begin
        row_neg = '0;
        for (int j = 0; j < MAP_SIZE; j++) begin
            row_neg = row_neg + NEG_W'(lane_neg[j]);
        end
    end

    // rd_vld_q/rd_addr_q line up with rd_data; the write stage is the single result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld_q  <= 1'b0;
            rd_addr_q <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            neg_cnt   <= '0;
            sat_flag  <= 1'b0;
        end else begin
            rd_vld_q  <= rd_en;
            rd_addr_q <= rd_addr;
            wr_en     <= rd_vld_q;
            if (rd_vld_q) begin
                wr_addr <= rd_addr_q;
                wr_data <= lane_y;
            end
            if (start_acc) begin
                neg_cnt  <= '0;
                sat_flag <= 1'b0;
            end else if (rd_vld_q) begin
                neg_cnt  <= neg_cnt + row_neg;
                sat_flag <= sat_flag | (|lane_sat);
            end
        end
    end

endmodule

// File: tb/tb_relu_map_sched.sv
// Directed + randomized bench for relu_map_sched at MAP_SIZE=4 with a 1-cycle-latency buffer model.
module tb_relu_map_sched;

    localparam int BW = 26;
    localparam int OW = 8;
    localparam int MS = 4;
    localparam int SW = 5;
    localparam int AW = 2;
    localparam int NW = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [SW-1:0]     cfg_shift;
    logic              busy, done, rd_en, wr_en, sat_flag;
    logic [AW-1:0]     rd_addr, wr_addr;
    logic [MS*BW-1:0]  rd_data = '0;
    logic [MS*OW-1:0]  wr_data;
    logic [NW-1:0]     neg_cnt;

    logic signed [BW-1:0] mem [MS][MS];

    int checks = 0;
    int errors = 0;

    relu_map_sched #(
        .BUF_WIDTH (BW),
        .OUT_WIDTH (OW),
        .MAP_SIZE  (MS),
        .SHIFT_W   (SW),
        .AW        (AW),
        .NEG_W     (NW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .cfg_shift (cfg_shift),
        .busy      (busy),
        .done      (done),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .neg_cnt   (neg_cnt),
        .sat_flag  (sat_flag)
    );

    always #5 clk = ~clk;

    // Synchronous-read accumulator buffer
    always @(posedge clk) begin
        if (rd_en) begin
            for (int j = 0; j < MS; j++) rd_data[j*BW +: BW] <= mem[rd_addr][j];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference arithmetic straight from the lane rules
    function automatic logic [7:0] ref_elem(input logic signed [BW-1:0] x, input int sh);
        int xi;
        int y;
        xi = x;
        if (xi < 0) return 8'd0;
        y = (sh >= 31) ? 0 : (xi >>> sh);
        if (y > 127) return 8'd127;
        return y[7:0];
    endfunction

    task automatic fill_random();
        for (int r = 0; r < MS; r++)
            for (int j = 0; j < MS; j++)
                case ($urandom_range(0, 3))
                    0:       mem[r][j] = BW'($urandom);
                    1:       mem[r][j] = BW'($urandom_range(0, 600)) - BW'(300);
                    2:       mem[r][j] = BW'($urandom_range(0, 40000));
                    default: mem[r][j] = '0;
                endcase
    endtask

    // cont: start is already held high from the previous run; keep: leave start high;
    // glitch: pulse start while busy and in the done cycle
    task automatic run_map(input int sh, input bit cont, input bit keep, input bit glitch);
        logic [MS*OW-1:0] exp_row [MS];
        int  exp_neg;
        bit  exp_sat;
        int  wr_seen;
        int  done_cyc;
        bit  busy_bad;
        bit  rd_bad;

        exp_neg = 0;
        exp_sat = 1'b0;
        for (int r = 0; r < MS; r++) begin
            for (int j = 0; j < MS; j++) begin
                exp_row[r][j*OW +: OW] = ref_elem(mem[r][j], sh);
                if (mem[r][j] < 0) exp_neg++;
                else if (sh < 31 && (int'(mem[r][j]) >>> sh) > 127) exp_sat = 1'b1;
            end
        end

        if (!cont) begin
            @(negedge clk);
            start = 1'b1;
            cfg_shift = SW'(sh);
        end else begin
            cfg_shift = SW'(sh);
            @(negedge clk);
            check("idle_gap_busy", busy, 0);
        end

        wr_seen = 0; done_cyc = 0; busy_bad = 0; rd_bad = 0;
        for (int n = 1; n <= 30 && done_cyc == 0; n++) begin
            @(negedge clk);
            if (n == 1 && !keep) start = 1'b0;
            if (glitch && n == 3) start = 1'b1;
            if (glitch && n == 4) start = 1'b0;
            if (busy !== (n <= MS + 2)) busy_bad = 1;
            if (rd_en !== (n <= MS) || (rd_en && rd_addr !== AW'(n - 1))) rd_bad = 1;
            if (wr_en) begin
                if (wr_seen < MS) begin
                    check("wr_cycle", n, 3 + wr_seen);
                    check("wr_addr", wr_addr, wr_seen);
                    check("wr_data", wr_data, exp_row[wr_seen]);
                end
                wr_seen++;
            end
            if (done) done_cyc = n;
        end
        check("done_cycle", done_cyc, MS + 3);
        check("num_writes", wr_seen, MS);
        check("busy_shape", busy_bad, 0);
        check("read_shape", rd_bad, 0);
        check("neg_cnt", neg_cnt, exp_neg);
        check("sat_flag", sat_flag, exp_sat);

        if (glitch) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check("start_in_done_ignored", busy, 0);
            @(negedge clk);
            check("still_idle_busy", busy, 0);
            check("still_idle_done", done, 0);
            check("neg_cnt_held", neg_cnt, exp_neg);
            check("sat_flag_held", sat_flag, exp_sat);
        end
    endtask

    initial begin
        bit wr_after_rst;

        rst_n = 1'b0;
        start = 1'b0;
        cfg_shift = '0;
        for (int r = 0; r < MS; r++)
            for (int j = 0; j < MS; j++) mem[r][j] = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd_en", rd_en, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_neg_cnt", neg_cnt, 0);
        check("rst_sat_flag", sat_flag, 0);
        rst_n = 1'b1;

        // Ramp, shift 0
        for (int r = 0; r < MS; r++)
            for (int j = 0; j < MS; j++) mem[r][j] = BW'(r * 4 + j);
        run_map(0, 0, 0, 0);

        // Odd lanes negative
        for (int r = 0; r < MS; r++)
            for (int j = 0; j < MS; j++) mem[r][j] = (j % 2 == 1) ? -BW'(5) : BW'(3);
        run_map(0, 0, 0, 0);
        check("neg_cnt_odd", neg_cnt, 8);

        // Saturation with shift 2
        for (int r = 0; r < MS; r++)
            for (int j = 0; j < MS; j++) mem[r][j] = '0;
        mem[0][1] = BW'(1000);
        mem[2][3] = BW'(400);
        run_map(2, 0, 0, 0);
        check("sat_flag_1000", sat_flag, 1);

        // Zero / minus-one / edge of saturation
        for (int r = 0; r < MS; r++) begin
            mem[r][0] = '0;
            mem[r][1] = -BW'(1);
            mem[r][2] = BW'(127);
            mem[r][3] = BW'(128);
        end
        run_map(0, 0, 0, 0);
        check("neg_cnt_minus1", neg_cnt, 4);

        // Max positive with shift 31, plus start pulses during busy and done
        for (int r = 0; r < MS; r++)
            for (int j = 0; j < MS; j++) mem[r][j] = BW'((1 << 25) - 1);
        run_map(31, 0, 0, 1);

        // Reset in the middle of a run
        for (int r = 0; r < MS; r++)
            for (int j = 0; j < MS; j++) mem[r][j] = BW'(r * 4 + j) - BW'(6);
        @(negedge clk);
        start = 1'b1;
        cfg_shift = '0;
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_rd_en", rd_en, 0);
        check("midrst_rd_addr", rd_addr, 0);
        check("midrst_wr_en", wr_en, 0);
        check("midrst_wr_addr", wr_addr, 0);
        check("midrst_wr_data", wr_data, 0);
        check("midrst_neg_cnt", neg_cnt, 0);
        wr_after_rst = 0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            if (wr_en || done) wr_after_rst = 1;
        end
        check("no_write_in_reset", wr_after_rst, 0);
        rst_n = 1'b1;
        run_map(0, 0, 0, 0);

        // start held high: back-to-back runs, shift re-latched each run
        fill_random();
        run_map(1, 0, 1, 0);
        fill_random();
        run_map(3, 1, 1, 0);
        fill_random();
        run_map(0, 1, 0, 0);

        // Randomized runs
        for (int k = 0; k < 6; k++) begin
            fill_random();
            run_map(int'($urandom_range(0, 31)), 0, 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
